// File: rtl/multi_ch_edge_det.sv
// -----------------------------------------------------------------------------
// multi_ch_edge_det
//
// Multi-channel edge detector and event capture. Each channel runs its input
// through a glitch filter, turns accepted level transitions into a one-cycle
// event pulse (qualified by a per-channel edge mode), and records events in a
// sticky flag and a saturating event counter. any_evt summarises all flags for
// an interrupt-style consumer.
//
// Optional feature macro: EDGE_DET_SYNC_EN
//   defined     : SYNC_STAGES-deep synchroniser per channel ahead of the
//                 filter, so sig_in may be asynchronous to clk.
//   not defined : sig_in feeds the filter directly and must be synchronous
//                 to clk; SYNC_STAGES has no effect.
//
// Parameters
//   NUM_CH       number of channels (>=1)
//   FILT_CYC     samples a new level must hold before it is accepted
//                (0 or 1 disables filtering)
//   CNT_W        width of each per-channel event counter (>=1)
//   SYNC_STAGES  synchroniser depth (>=2), only with EDGE_DET_SYNC_EN
//
// Ports
//   clk       in   single clock, all logic on posedge
//   rst       in   synchronous active-high reset
//   sig_in    in   [NUM_CH]        raw input levels
//   mode      in   [2*NUM_CH]      ch i = mode[2i+1:2i]: 00 off, 01 rise,
//                                  10 fall, 11 both
//   clr_flag  in   [NUM_CH]        level clear of flag and counter
//   pulse     out  [NUM_CH]        registered one-cycle event pulse
//   flag      out  [NUM_CH]        sticky event flag
//   evt_cnt   out  [NUM_CH*CNT_W]  saturating counters, ch i at [i*CNT_W +: CNT_W]
//   any_evt   out                  OR of all flags
// -----------------------------------------------------------------------------
module multi_ch_edge_det #(
    parameter int NUM_CH      = 8,
    parameter int FILT_CYC    = 4,
    parameter int CNT_W       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_CH-1:0]         sig_in,
    input  logic [2*NUM_CH-1:0]       mode,
    input  logic [NUM_CH-1:0]         clr_flag,
    output logic [NUM_CH-1:0]         pulse,
    output logic [NUM_CH-1:0]         flag,
    output logic [NUM_CH*CNT_W-1:0]   evt_cnt,
    output logic                      any_evt
);

    // Synchroniser depth actually built; 0 means the input is used directly.
`ifdef EDGE_DET_SYNC_EN
    localparam int SYNC_DEPTH = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
`else
    localparam int SYNC_DEPTH = 0;
`endif

    // Filter counter only needs to reach FILT_CYC-1.
    localparam int              FW        = (FILT_CYC > 2) ? $clog2(FILT_CYC) : 1;
    localparam logic [FW-1:0]   FILT_LAST = FW'((FILT_CYC > 1) ? FILT_CYC - 1 : 0);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    logic [NUM_CH-1:0] s_in;

    // ------------------------------------------------------------------------
    // Input synchroniser (optional)
    // ------------------------------------------------------------------------
    if (SYNC_DEPTH > 0) begin : g_sync
        logic [NUM_CH-1:0] sync_q [SYNC_DEPTH];
        logic [NUM_CH-1:0] sync_d [SYNC_DEPTH];

        always_comb begin
            sync_d[0] = sig_in;
            for (int k = 1; k < SYNC_DEPTH; k++) begin
                sync_d[k] = sync_q[k-1];
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                for (int k = 0; k < SYNC_DEPTH; k++) begin
                    sync_q[k] <= '0;
                end
            end else begin
                for (int k = 0; k < SYNC_DEPTH; k++) begin
                    sync_q[k] <= sync_d[k];
                end
            end
        end

        assign s_in = sync_q[SYNC_DEPTH-1];
    end else begin : g_nosync
        assign s_in = sig_in;
    end

    // ------------------------------------------------------------------------
    // Per-channel filter, event qualification, flag and counter
    // ------------------------------------------------------------------------
    logic [FW-1:0]     filt_cnt_q [NUM_CH];
    logic [FW-1:0]     filt_cnt_d [NUM_CH];
    logic [NUM_CH-1:0] lvl_q;
    logic [NUM_CH-1:0] lvl_d;
    logic [NUM_CH-1:0] pulse_q;
    logic [NUM_CH-1:0] pulse_d;
    logic [NUM_CH-1:0] flag_q;
    logic [NUM_CH-1:0] flag_d;
    logic [CNT_W-1:0]  cnt_q [NUM_CH];
    logic [CNT_W-1:0]  cnt_d [NUM_CH];
    logic [NUM_CH-1:0] evt;

    always_comb begin
        lvl_d   = lvl_q;
        pulse_d = '0;
        flag_d  = flag_q;
        evt     = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            filt_cnt_d[i] = filt_cnt_q[i];
            cnt_d[i]      = cnt_q[i];
        end

        for (int i = 0; i < NUM_CH; i++) begin
            // Filtered level f only moves after FILT_CYC consecutive
            // samples that disagree with it; any agreeing sample restarts.
            if (FILT_CYC <= 1) begin
                lvl_d[i]      = s_in[i];
                filt_cnt_d[i] = '0;
            end else if (s_in[i] == lvl_q[i]) begin
                filt_cnt_d[i] = '0;
            end else if (filt_cnt_q[i] == FILT_LAST) begin
                lvl_d[i]      = s_in[i];
                filt_cnt_d[i] = '0;
            end else begin
                filt_cnt_d[i] = filt_cnt_q[i] + FW'(1);
            end

            // Events come only from f transitions; mode just gates them.
            evt[i] = ( lvl_d[i] & ~lvl_q[i] & mode[2*i])
                   | (~lvl_d[i] &  lvl_q[i] & mode[2*i+1]);

            pulse_d[i] = evt[i];

            // A coincident event wins over a clear.
            flag_d[i] = evt[i] | (flag_q[i] & ~clr_flag[i]);

            if (clr_flag[i]) begin
                cnt_d[i] = evt[i] ? CNT_W'(1) : '0;
            end else if (evt[i] && (cnt_q[i] != CNT_MAX)) begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lvl_q   <= '0;
            pulse_q <= '0;
            flag_q  <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                filt_cnt_q[i] <= '0;
                cnt_q[i]      <= '0;
            end
        end else begin
            lvl_q   <= lvl_d;
            pulse_q <= pulse_d;
            flag_q  <= flag_d;
            for (int i = 0; i < NUM_CH; i++) begin
                filt_cnt_q[i] <= filt_cnt_d[i];
                cnt_q[i]      <= cnt_d[i];
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    always_comb begin
        evt_cnt = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            evt_cnt[i*CNT_W +: CNT_W] = cnt_q[i];
        end
    end

    assign pulse   = pulse_q;
    assign flag    = flag_q;
    assign any_evt = |flag_q;

endmodule

// File: tb/tb_multi_ch_edge_det.sv
module tb_multi_ch_edge_det;

    localparam int NUM_CH      = 8;
    localparam int FILT_CYC    = 4;
    localparam int CNT_W       = 8;
    localparam int SYNC_STAGES = 2;
`ifdef EDGE_DET_SYNC_EN
    localparam int LAT = FILT_CYC + SYNC_STAGES;
`else
    localparam int LAT = FILT_CYC;
`endif

    logic                    clk;
    logic                    rst;
    logic [NUM_CH-1:0]       sig_in;
    logic [2*NUM_CH-1:0]     mode;
    logic [NUM_CH-1:0]       clr_flag;
    logic [NUM_CH-1:0]       pulse;
    logic [NUM_CH-1:0]       flag;
    logic [NUM_CH*CNT_W-1:0] evt_cnt;
    logic                    any_evt;

    multi_ch_edge_det #(
        .NUM_CH     (NUM_CH),
        .FILT_CYC   (FILT_CYC),
        .CNT_W      (CNT_W),
        .SYNC_STAGES(SYNC_STAGES)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .sig_in  (sig_in),
        .mode    (mode),
        .clr_flag(clr_flag),
        .pulse   (pulse),
        .flag    (flag),
        .evt_cnt (evt_cnt),
        .any_evt (any_evt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        logic [7:0]  pulse;
        logic [7:0]  flag;
        logic [63:0] cnt;
    } exp_t;

    exp_t       sb_q[$];
    exp_t       mon_e;
    int         checks = 0;
    int         errors = 0;
    int         exp_cnt[NUM_CH];
    logic [7:0] exp_flag;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    function automatic logic [63:0] pack_cnt();
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < NUM_CH; i++) r[i*8 +: 8] = exp_cnt[i][7:0];
        return r;
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Expect a pulse on the channels in mask, LAT edges after the input
    // change made at the current cycle.
    task automatic expect_evt(input logic [7:0] mask);
        exp_t e;
        for (int i = 0; i < NUM_CH; i++) begin
            if (mask[i]) begin
                if (exp_cnt[i] < 255) exp_cnt[i]++;
                exp_flag[i] = 1'b1;
            end
        end
        e.cyc   = cyc + LAT;
        e.pulse = mask;
        e.flag  = exp_flag;
        e.cnt   = pack_cnt();
        sb_q.push_back(e);
    endtask

    task automatic chk_state(input string name);
        chk({name, "_flag"},    64'(flag),    64'(exp_flag));
        chk({name, "_cnt"},     evt_cnt,      pack_cnt());
        chk({name, "_any_evt"}, 64'(any_evt), 64'(|exp_flag));
    endtask

    task automatic clear_ch(input int ch);
        clr_flag[ch] = 1'b1;
        step(1);
        clr_flag[ch] = 1'b0;
        exp_cnt[ch]  = 0;
        exp_flag[ch] = 1'b0;
    endtask

    task automatic set_mode(input int ch, input logic [1:0] m);
        mode[2*ch +: 2] = m;
    endtask

    // Monitor: every pulse the DUT presents must match the next expectation.
    always @(negedge clk) begin
        if (pulse !== '0) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse: got %b, expected none (cycle %0d)", pulse, cyc);
            end else begin
                mon_e = sb_q.pop_front();
                chk("pulse_cycle", 64'(cyc),     64'(mon_e.cyc));
                chk("pulse_vec",   64'(pulse),   64'(mon_e.pulse));
                chk("pulse_flag",  64'(flag),    64'(mon_e.flag));
                chk("pulse_cnt",   evt_cnt,      mon_e.cnt);
                chk("pulse_any",   64'(any_evt), 64'(|mon_e.flag));
            end
        end
    end

    initial begin
        rst      = 1'b1;
        sig_in   = '0;
        mode     = '0;
        clr_flag = '0;
        exp_flag = '0;
        for (int i = 0; i < NUM_CH; i++) exp_cnt[i] = 0;
        step(3);
        rst = 1'b0;
        chk("reset_pulse", 64'(pulse), 64'h0);
        chk_state("reset");
        step(2);

        // 1: single rise on ch0
        set_mode(0, 2'b01);
        sig_in[0] = 1'b1;
        expect_evt(8'h01);
        step(10);
        chk_state("t1_after_rise");
        sig_in[0] = 1'b0;
        step(10);
        chk_state("t1_fall_ignored");
        clear_ch(0);
        chk_state("t1_cleared");

        // 2: 3-sample glitch dropped, 4-sample pulse gives rise and fall
        set_mode(1, 2'b11);
        sig_in[1] = 1'b1;
        step(3);
        sig_in[1] = 1'b0;
        step(8);
        chk_state("t2_glitch");
        sig_in[1] = 1'b1;
        expect_evt(8'h02);
        step(4);
        sig_in[1] = 1'b0;
        expect_evt(8'h02);
        step(LAT + 4);
        chk_state("t2_both");
        clear_ch(1);

        // 3: fall-only mode, off mode, mode change with f already high
        set_mode(2, 2'b10);
        sig_in[2] = 1'b1;
        step(6);
        sig_in[2] = 1'b0;
        expect_evt(8'h04);
        step(LAT + 4);
        chk_state("t3_fall_only");
        set_mode(2, 2'b00);
        sig_in[2] = 1'b1;
        step(LAT + 2);
        sig_in[2] = 1'b0;
        step(LAT + 2);
        sig_in[2] = 1'b1;
        step(LAT + 2);
        set_mode(2, 2'b01);
        step(LAT + 2);
        chk_state("t3_mode_change");
        set_mode(2, 2'b00);
        sig_in[2] = 1'b0;
        step(LAT + 2);
        clear_ch(2);

        // 4: counter saturation, then clear coincident with an event
        set_mode(3, 2'b01);
        for (int n = 0; n < 300; n++) begin
            sig_in[3] = 1'b1;
            expect_evt(8'h08);
            step(LAT);
            sig_in[3] = 1'b0;
            step(LAT);
        end
        chk_state("t4_saturated");
        exp_cnt[3]  = 0;
        exp_flag[3] = 1'b0;
        sig_in[3] = 1'b1;
        expect_evt(8'h08);
        step(LAT - 1);
        clr_flag[3] = 1'b1;
        step(1);
        clr_flag[3] = 1'b0;
        step(1);
        chk_state("t4_clr_with_evt");
        sig_in[3] = 1'b0;
        step(LAT + 4);

        // 5: reset while a filter count is in progress
        set_mode(4, 2'b11);
        sig_in[4] = 1'b1;
        step(2);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        exp_flag = '0;
        for (int i = 0; i < NUM_CH; i++) exp_cnt[i] = 0;
        chk("t5_pulse", 64'(pulse), 64'h0);
        chk_state("t5_reset");
        expect_evt(8'h10);
        step(LAT + 4);
        sig_in[4] = 1'b0;
        expect_evt(8'h10);
        step(LAT + 4);
        chk_state("t5_after");

        // simultaneous events on several channels
        set_mode(5, 2'b01);
        set_mode(6, 2'b01);
        set_mode(7, 2'b11);
        sig_in[7:5] = 3'b111;
        expect_evt(8'hE0);
        step(LAT + 4);
        sig_in[7:5] = 3'b000;
        expect_evt(8'h80);
        step(LAT + 4);
        chk_state("multi");

        step(10);
        chk("sb_empty", 64'(sb_q.size()), 64'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
